// File: rtl/jtkiwi_vram_sched_pkg.sv
// Shared definitions for the code-VRAM time-slot scheduler: slot IDs, CPU FSM states, bus widths.
package jtkiwi_vram_sched_pkg;

   localparam int unsigned VRAM_AW = 12;
   localparam int unsigned VRAM_DW = 16;

   localparam logic [1:0] SLOT_TM   = 2'd0;
   localparam logic [1:0] SLOT_CPU0 = 2'd1;
   localparam logic [1:0] SLOT_OBJ  = 2'd2;
   localparam logic [1:0] SLOT_CPU1 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cpu_state_t;

endpackage

// File: rtl/jtkiwi_sched_cpu.sv
// CPU side of the VRAM scheduler: takes a free slot, holds the CPU in wait and captures read data.
module jtkiwi_sched_cpu
   import jtkiwi_vram_sched_pkg::*;
#(
   parameter int unsigned DW = VRAM_DW
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            slot_free,
   input  logic            cpu_req,
   input  logic            cpu_rnw,
   input  logic            cpu_a12,
   input  logic [DW-1:0]   mem_dout,
   output logic            grant,
   output logic            cpu_wait,
   output logic [DW/2-1:0] cpu_din
);

   cpu_state_t state;
   logic       a12_q;

   // Grant is combinational so the address reaches the VRAM in the slot itself.
   assign grant    = slot_free & cpu_req & (state == ST_IDLE);
   assign cpu_wait = cpu_req & (state != ST_DONE);

   // Read data is valid during GRANT, so it is latched on the edge entering CAPTURE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         a12_q   <= 1'b0;
         cpu_din <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  state <= ST_GRANT;
                  a12_q <= cpu_a12;
               end
            end
            ST_GRANT: begin
               if (!cpu_req) begin
                  state <= ST_IDLE;
               end else if (cpu_rnw) begin
                  cpu_din <= a12_q ? mem_dout[DW-1:DW/2] : mem_dout[DW/2-1:0];
                  state   <= ST_CAPTURE;
               end else begin
                  state <= ST_DONE;
               end
            end
            ST_CAPTURE: state <= ST_DONE;
            ST_DONE: begin
               if (!cpu_req) state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/jtkiwi_vram_sched.sv
// Time-slot scheduler sharing the single-port code VRAM between tilemap, object LUT and CPU.
// Define JTKIWI_VBLANK_CPU_EN to let a pending CPU request also take GFX slots while LVBL is low.
module jtkiwi_vram_sched
   import jtkiwi_vram_sched_pkg::*;
#(
   parameter int unsigned AW = VRAM_AW,
   parameter int unsigned DW = VRAM_DW
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            LVBL,
   input  logic            cpu_req,
   input  logic            cpu_rnw,
   input  logic [AW:0]     cpu_addr,
   input  logic [DW/2-1:0] cpu_dout,
   output logic [DW/2-1:0] cpu_din,
   output logic            cpu_wait,
   input  logic [AW-1:0]   tm_addr,
   output logic            tm_cen,
   output logic [DW-1:0]   tm_data,
   input  logic [AW-1:0]   lut_addr,
   output logic            lut_cen,
   output logic [DW-1:0]   lut_data,
   output logic [AW-1:0]   mem_addr,
   output logic [1:0]      mem_we,
   output logic [DW-1:0]   mem_din,
   input  logic [DW-1:0]   mem_dout
);

   logic [1:0] slot;
   logic       gfx_slot;
   logic       vb_cpu;
   logic       slot_free;
   logic       grant;
   logic       gfx_own;

   assign gfx_slot = (slot == SLOT_TM) || (slot == SLOT_OBJ);

`ifdef JTKIWI_VBLANK_CPU_EN
   assign vb_cpu = ~LVBL;
`else
   logic unused_lvbl;
   assign unused_lvbl = LVBL;
   assign vb_cpu      = 1'b0;
`endif

   assign slot_free = ~rst & (~gfx_slot | vb_cpu);
   assign tm_cen    = ~rst & (slot == SLOT_TM);
   assign lut_cen   = ~rst & (slot == SLOT_OBJ);

   // A GFX slot taken by the CPU drives the CPU address instead.
   always_comb begin
      mem_addr = cpu_addr[AW-1:0];
      if (!grant) begin
         if (slot == SLOT_TM)       mem_addr = tm_addr;
         else if (slot == SLOT_OBJ) mem_addr = lut_addr;
      end
   end

   assign mem_we  = (grant && !cpu_rnw) ? {cpu_addr[AW], ~cpu_addr[AW]} : 2'b00;
   assign mem_din = {2{cpu_dout}};

   jtkiwi_sched_cpu #(.DW(DW)) u_cpu (
      .clk       (clk),
      .rst       (rst),
      .slot_free (slot_free),
      .cpu_req   (cpu_req),
      .cpu_rnw   (cpu_rnw),
      .cpu_a12   (cpu_addr[AW]),
      .mem_dout  (mem_dout),
      .grant     (grant),
      .cpu_wait  (cpu_wait),
      .cpu_din   (cpu_din)
   );

   // gfx_own remembers whether the previous slot's read belongs to the GFX side.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot     <= SLOT_TM;
         gfx_own  <= 1'b0;
         tm_data  <= '0;
         lut_data <= '0;
      end else begin
         slot    <= slot + 2'd1;
         gfx_own <= gfx_slot & ~grant;
         if (gfx_own && slot == SLOT_CPU0) tm_data  <= mem_dout;
         if (gfx_own && slot == SLOT_CPU1) lut_data <= mem_dout;
      end
   end

endmodule

// File: tb/tb_jtkiwi_vram_sched.sv
// Bench for jtkiwi_vram_sched: synchronous VRAM model, access-level reference model, directed tests.
module tb_jtkiwi_vram_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        LVBL = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_rnw = 1'b1;
   logic [12:0] cpu_addr = 13'd0;
   logic [7:0]  cpu_dout = 8'd0;
   logic [7:0]  cpu_din;
   logic        cpu_wait;
   logic [11:0] tm_addr = 12'd0;
   logic        tm_cen;
   logic [15:0] tm_data;
   logic [11:0] lut_addr = 12'd0;
   logic        lut_cen;
   logic [15:0] lut_data;
   logic [11:0] mem_addr;
   logic [1:0]  mem_we;
   logic [15:0] mem_din;
   logic [15:0] mem_dout = 16'd0;

   int n_vec = 0;
   int n_err = 0;

`ifdef JTKIWI_VBLANK_CPU_EN
   localparam bit VB = 1'b1;
`else
   localparam bit VB = 1'b0;
`endif

   jtkiwi_vram_sched dut (
      .clk(clk), .rst(rst), .LVBL(LVBL),
      .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .cpu_wait(cpu_wait),
      .tm_addr(tm_addr), .tm_cen(tm_cen), .tm_data(tm_data),
      .lut_addr(lut_addr), .lut_cen(lut_cen), .lut_data(lut_data),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Synchronous single-port VRAM, read-before-write, plus a bench poke port.
   logic [15:0] mem [0:4095];
   logic        mem_clr = 1'b0;
   logic        poke_en = 1'b0;
   logic [11:0] poke_addr = 12'd0;
   logic [15:0] poke_val = 16'd0;

   always @(posedge clk) begin
      mem_dout <= mem[mem_addr];
      if (mem_clr) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 16'd0;
      end else begin
         if (mem_we[0]) mem[mem_addr][7:0]  <= mem_din[7:0];
         if (mem_we[1]) mem[mem_addr][15:8] <= mem_din[15:8];
         if (poke_en)   mem[poke_addr]      <= poke_val;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: slot = cycle count mod 4; a CPU access is tracked by cycles since its grant.
   int          m_slot = 0;
   int          m_age = 0;
   bit          m_rd, m_a12, m_served, m_gv, mg;
   logic [15:0] m_rdval, m_gval, m_tm, m_lut;
   logic [7:0]  m_din;

   function automatic bit cpu_owns_slot();
      return (m_slot % 2 == 1) || (VB && !LVBL);
   endfunction

   function automatic bit exp_grant();
      return !rst && cpu_req && m_age == 0 && !m_served && cpu_owns_slot();
   endfunction

   function automatic logic [11:0] exp_addr();
      if (!exp_grant() && m_slot == 0) return tm_addr;
      if (!exp_grant() && m_slot == 2) return lut_addr;
      return cpu_addr[11:0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_slot = 0; m_age = 0; m_served = 1'b0; m_gv = 1'b0;
         m_din = 8'd0; m_tm = 16'd0; m_lut = 16'd0;
      end else begin
         mg = exp_grant();
         if (m_slot == 1 && m_gv) m_tm  = m_gval;
         if (m_slot == 3 && m_gv) m_lut = m_gval;
         m_gv = (m_slot % 2 == 0) && !mg;
         if (m_gv) m_gval = mem[exp_addr()];
         if (mg) begin
            m_age = 1; m_rd = cpu_rnw; m_a12 = cpu_addr[12]; m_rdval = mem[cpu_addr[11:0]];
         end else if (m_age == 1) begin
            if (!cpu_req) m_age = 0;
            else if (m_rd) begin
               m_din = m_a12 ? m_rdval[15:8] : m_rdval[7:0];
               m_age = 2;
            end else begin
               m_age = 0; m_served = 1'b1;
            end
         end else if (m_age == 2) begin
            m_age = 0; m_served = 1'b1;
         end else if (m_served && !cpu_req) begin
            m_served = 1'b0;
         end
         m_slot = (m_slot + 1) % 4;
      end
   end

   bit         cg;
   logic [1:0] e_we;

   always @(negedge clk) begin
      cg   = exp_grant();
      e_we = (cg && !cpu_rnw) ? {cpu_addr[12], ~cpu_addr[12]} : 2'b00;
      check("tm_cen",   32'(tm_cen),   32'(!rst && m_slot == 0));
      check("lut_cen",  32'(lut_cen),  32'(!rst && m_slot == 2));
      check("mem_addr", 32'(mem_addr), 32'(exp_addr()));
      check("mem_we",   32'(mem_we),   32'(e_we));
      check("mem_din",  32'(mem_din),  32'({cpu_dout, cpu_dout}));
      check("cpu_wait", 32'(cpu_wait), 32'(cpu_req && !m_served));
      check("cpu_din",  32'(cpu_din),  32'(m_din));
      check("tm_data",  32'(tm_data),  32'(m_tm));
      check("lut_data", 32'(lut_data), 32'(m_lut));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [11:0] a, input logic [15:0] v);
      poke_addr = a; poke_val = v; poke_en = 1'b1;
      tick();
      poke_en = 1'b0;
   endtask

   task automatic wait_slot(input int s);
      for (int i = 0; i < 8; i++) begin
         if (m_slot == s) break;
         tick();
      end
      if (m_slot != s) begin
         n_err++;
         $display("FAIL wait_slot: slot %0d not reached, at %0d", s, m_slot);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pulses;
      tm_addr  = 12'h123;
      lut_addr = 12'h200;
      mem_clr  = 1'b1;
      tick();
      mem_clr  = 1'b0;
      poke(12'h123, 16'hBEEF);
      poke(12'h200, 16'h1234);
      poke(12'h005, 16'hA55A);

      // reset values
      check("rst_tm_cen",   32'(tm_cen),   32'd0);
      check("rst_lut_cen",  32'(lut_cen),  32'd0);
      check("rst_tm_data",  32'(tm_data),  32'd0);
      check("rst_cpu_din",  32'(cpu_din),  32'd0);
      check("rst_mem_we",   32'(mem_we),   32'd0);

      // 1: idle tilemap/object fetch
      rst = 1'b0;
      #1;
      check("t1_tm_cen_s0", 32'(tm_cen), 32'd1);
      tick();
      check("t1_tm_cen_s1", 32'(tm_cen), 32'd0);
      tick();
      check("t1_tm_data",   32'(tm_data), 32'hBEEF);
      check("t1_lut_cen",   32'(lut_cen), 32'd1);
      tick();
      tick();
      check("t1_tm_cen_s4", 32'(tm_cen),   32'd1);
      check("t1_lut_data",  32'(lut_data), 32'h1234);

      // 2: CPU read, high lane, request in slot 2
      wait_slot(2);
      cpu_addr = 13'h1005; cpu_rnw = 1'b1; cpu_req = 1'b1;
      #1;
      check("t2_wait_rise", 32'(cpu_wait), 32'd1);
      tick();
      check("t2_grant_addr", 32'(mem_addr), 32'h005);
      check("t2_grant_we",   32'(mem_we),   32'd0);
      tick();
      check("t2_wait_grant", 32'(cpu_wait), 32'd1);
      tick();
      check("t2_wait_capt",  32'(cpu_wait), 32'd1);
      tick();
      check("t2_wait_low",   32'(cpu_wait), 32'd0);
      check("t2_cpu_din",    32'(cpu_din),  32'hA5);
      cpu_req = 1'b0;
      tick();

      // 3: CPU write, low lane, in slot 1
      wait_slot(1);
      cpu_addr = 13'h0010; cpu_rnw = 1'b0; cpu_dout = 8'h77; cpu_req = 1'b1;
      #1;
      check("t3_we",   32'(mem_we),   32'b01);
      check("t3_din",  32'(mem_din),  32'h7777);
      check("t3_addr", 32'(mem_addr), 32'h010);
      tick();
      check("t3_we_once",  32'(mem_we),   32'd0);
      check("t3_wait_hi",  32'(cpu_wait), 32'd1);
      tick();
      check("t3_wait_low", 32'(cpu_wait), 32'd0);
      cpu_req = 1'b0;
      tick();
      check("t3_mem", 32'(mem[12'h010]), 32'h0077);

      // 4: held request is served once; re-request gives a second access
      cpu_addr = 13'h1020; cpu_rnw = 1'b0; cpu_dout = 8'h5A; cpu_req = 1'b1;
      #1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_we != 2'b00) pulses++;
         tick();
      end
      check("t4_one_pulse", 32'(pulses), 32'd1);
      check("t4_mem", 32'(mem[12'h020]), 32'h5A00);
      cpu_req = 1'b0;
      tick();
      tick();
      cpu_dout = 8'h3C; cpu_req = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         if (mem_we != 2'b00) pulses++;
         tick();
      end
      check("t4_second", 32'(pulses), 32'd2);
      cpu_req = 1'b0;
      tick();
      tick();

      // 5: reset while a write is in GRANT
      cpu_addr = 13'h0030; cpu_rnw = 1'b0; cpu_dout = 8'h11; cpu_req = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         if (mem_we != 2'b00) break;
         tick();
      end
      check("t5_grant_seen", 32'(mem_we != 2'b00), 32'd1);
      tick();
      check("t5_in_grant", 32'(cpu_wait), 32'd1);
      rst = 1'b1;
      #1;
      check("t5_rst_we",   32'(mem_we),   32'd0);
      check("t5_rst_wait", 32'(cpu_wait), 32'd1);
      tick();
      check("t5_rst_we2",  32'(mem_we),   32'd0);
      rst = 1'b0;
      #1;
      check("t5_slot0",    32'(tm_cen),   32'd1);
      check("t5_post_we",  32'(mem_we),   32'd0);
      check("t5_post_wait",32'(cpu_wait), 32'd1);
      cpu_req = 1'b0;
      #1;
      check("t5_wait_drop",32'(cpu_wait), 32'd0);
      tick();

      // 6: slot 0 with LVBL low; GFX data holds only when the CPU took the slot
      poke(12'h040, 16'h9876);
      poke(12'h123, 16'hC0DE);
      repeat (8) tick();
      check("t6_tm_pre", 32'(tm_data), 32'hC0DE);
      poke(12'h123, 16'hD00D);
      LVBL = 1'b0;
      wait_slot(0);
      cpu_addr = 13'h0040; cpu_rnw = 1'b1; cpu_req = 1'b1;
      #1;
`ifdef JTKIWI_VBLANK_CPU_EN
      check("t6_vb_grant_addr", 32'(mem_addr), 32'h040);
      check("t6_vb_tm_cen",     32'(tm_cen),   32'd1);
      tick();
      tick();
      check("t6_vb_tm_hold",    32'(tm_data),  32'hC0DE);
      tick();
`else
      check("t6_nv_tm_addr",    32'(mem_addr), 32'h123);
      tick();
      check("t6_nv_grant_addr", 32'(mem_addr), 32'h040);
      tick();
      check("t6_nv_tm_load",    32'(tm_data),  32'hD00D);
      tick();
      tick();
`endif
      check("t6_wait_low", 32'(cpu_wait), 32'd0);
      check("t6_cpu_din",  32'(cpu_din),  32'h76);
      cpu_req = 1'b0;
      tick();

      // 6b: same request with LVBL high waits for slot 1
      LVBL = 1'b1;
      wait_slot(0);
      cpu_addr = 13'h1040; cpu_rnw = 1'b1; cpu_req = 1'b1;
      #1;
      check("t6b_tm_keeps", 32'(mem_addr), 32'h123);
      tick();
      check("t6b_grant_addr", 32'(mem_addr), 32'h040);
      tick();
      tick();
      tick();
      check("t6b_wait_low", 32'(cpu_wait), 32'd0);
      check("t6b_cpu_din",  32'(cpu_din),  32'h98);
      cpu_req = 1'b0;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
